frequency_pixel_emitter: RTL and testbench

- **Role:** transmit side of the pixel-blink frequency link.
- **Function:** serialises a data word MSB-first. Each bit becomes a fixed-length burst of square wave on one emitter output: FREQUENCY0 for a 0, FREQUENCY1 for a 1. Bursts are followed by an idle-low gap.
- **Placement:** drives the LED/light source that a camera pixel watches. The frequency analyzer chain at the far end measures the same two frequencies, so defaults match pixel-0 analyzer defaults.

---
 rtl/frequency_pixel_emitter.sv | 209 ++++++++++++++++++++
 tb/tb_frequency_pixel_emitter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/frequency_pixel_emitter.sv
// frequency_pixel_emitter: serialises a word MSB-first onto a light source.
// Each bit becomes a fixed-length square-wave burst (FREQUENCY0 for a 0,
// FREQUENCY1 for a 1). An idle-low gap follows the last bit, and done pulses
// for one cycle. The stop input aborts from any state.
module frequency_pixel_emitter #(
   parameter int CLOCK_FREQUENCY = 100000000,
   parameter int FREQUENCY0      = 9000,
   parameter int FREQUENCY1      = 11000,
   parameter int WORD_WIDTH      = 8,
   parameter int SYMBOL_CYCLES   = 1000000,
   parameter int GAP_CYCLES      = 1000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] data,
   input  logic                  start,
   input  logic                  stop,
   output logic                  ready,
   output logic                  busy,
   output logic                  emitter,
   output logic                  current_bit,
   output logic                  done
);

   // Half-period lengths, in clock cycles, for each tone.
   localparam int HALF0 = CLOCK_FREQUENCY / (2 * FREQUENCY0);
   localparam int HALF1 = CLOCK_FREQUENCY / (2 * FREQUENCY1);
   localparam int HMAX  = (HALF0 > HALF1) ? HALF0 : HALF1;

   // Counter widths are sized to the terminal count, with a minimum of 1 bit.
   localparam int HW = (HMAX > 1)          ? $clog2(HMAX)          : 1;
   localparam int SW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 1)    ? $clog2(GAP_CYCLES)    : 1;
   localparam int BW = (WORD_WIDTH > 1)    ? $clog2(WORD_WIDTH)    : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYMBOL = 2'd1,
      ST_GAP    = 2'd2
   } t_state;

   t_state                r_state;
   logic [WORD_WIDTH-1:0] r_shift;
   logic [BW-1:0]         r_bit_cnt;
   logic [HW-1:0]         r_half_cnt;
   logic [SW-1:0]         r_sym_cnt;
   logic [GW-1:0]         r_gap_cnt;
   logic                  r_emitter;
   logic                  r_cur_bit;
   logic                  r_done;
   logic                  r_ready;
   logic                  r_busy;

   t_state                w_state_nxt;
   logic [WORD_WIDTH-1:0] w_shift_nxt;
   logic [BW-1:0]         w_bit_cnt_nxt;
   logic [HW-1:0]         w_half_cnt_nxt;
   logic [SW-1:0]         w_sym_cnt_nxt;
   logic [GW-1:0]         w_gap_cnt_nxt;
   logic                  w_emitter_nxt;
   logic                  w_cur_bit_nxt;
   logic                  w_done_nxt;
   logic                  w_ready_nxt;
   logic                  w_busy_nxt;

   logic [WORD_WIDTH-1:0] w_shifted;
   logic [HW-1:0]         w_half_term;

   // The tone of the bit currently on air selects the half-period terminal count.
   assign w_shifted   = r_shift << 1;
   assign w_half_term = r_cur_bit ? HW'(HALF1 - 1) : HW'(HALF0 - 1);

   // Next-state and next-output logic. stop overrides every other transition.
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_half_cnt_nxt = r_half_cnt;
      w_sym_cnt_nxt  = r_sym_cnt;
      w_gap_cnt_nxt  = r_gap_cnt;
      w_emitter_nxt  = r_emitter;
      w_cur_bit_nxt  = r_cur_bit;
      w_done_nxt     = 1'b0;
      w_ready_nxt    = r_ready;
      w_busy_nxt     = r_busy;

      if (stop) begin
         w_state_nxt    = ST_IDLE;
         w_bit_cnt_nxt  = '0;
         w_half_cnt_nxt = '0;
         w_sym_cnt_nxt  = '0;
         w_gap_cnt_nxt  = '0;
         w_emitter_nxt  = 1'b0;
         w_cur_bit_nxt  = 1'b0;
         w_ready_nxt    = 1'b1;
         w_busy_nxt     = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_ready_nxt   = 1'b1;
               w_busy_nxt    = 1'b0;
               w_emitter_nxt = 1'b0;
               w_cur_bit_nxt = 1'b0;
               if (start) begin
                  // Accept the word; the first burst begins high on the next cycle.
                  w_state_nxt    = ST_SYMBOL;
                  w_shift_nxt    = data;
                  w_bit_cnt_nxt  = '0;
                  w_half_cnt_nxt = '0;
                  w_sym_cnt_nxt  = '0;
                  w_emitter_nxt  = 1'b1;
                  w_cur_bit_nxt  = data[WORD_WIDTH-1];
                  w_ready_nxt    = 1'b0;
                  w_busy_nxt     = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_SYMBOL: begin
               if (r_sym_cnt == SW'(SYMBOL_CYCLES - 1)) begin
                  w_half_cnt_nxt = '0;
                  w_sym_cnt_nxt  = '0;
                  if (r_bit_cnt == BW'(WORD_WIDTH - 1)) begin
                     w_state_nxt   = ST_GAP;
                     w_gap_cnt_nxt = '0;
                     w_emitter_nxt = 1'b0;
                     w_cur_bit_nxt = 1'b0;
                  end else begin
                     // Restart the next bit in phase, so every burst opens high.
                     w_shift_nxt   = w_shifted;
                     w_bit_cnt_nxt = r_bit_cnt + BW'(1'b1);
                     w_emitter_nxt = 1'b1;
                     w_cur_bit_nxt = w_shifted[WORD_WIDTH-1];
                  end
               end else begin
                  w_sym_cnt_nxt = r_sym_cnt + SW'(1'b1);
                  // A half period longer than the symbol never reaches its terminal count.
                  if (r_half_cnt == w_half_term) begin
                     w_half_cnt_nxt = '0;
                     w_emitter_nxt  = ~r_emitter;
                  end else begin
                     w_half_cnt_nxt = r_half_cnt + HW'(1'b1);
                  end
               end
            end
            ST_GAP: begin
               w_emitter_nxt = 1'b0;
               w_cur_bit_nxt = 1'b0;
               if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  w_state_nxt   = ST_IDLE;
                  w_gap_cnt_nxt = '0;
                  w_done_nxt    = 1'b1;
                  w_ready_nxt   = 1'b1;
                  w_busy_nxt    = 1'b0;
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt + GW'(1'b1);
               end
            end
            default: begin
               w_state_nxt    = ST_IDLE;
               w_bit_cnt_nxt  = '0;
               w_half_cnt_nxt = '0;
               w_sym_cnt_nxt  = '0;
               w_gap_cnt_nxt  = '0;
               w_emitter_nxt  = 1'b0;
               w_cur_bit_nxt  = 1'b0;
               w_ready_nxt    = 1'b1;
               w_busy_nxt     = 1'b0;
            end
         endcase
      end
   end

   // State, counter and output registers; reset clears them at once, without a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_half_cnt <= '0;
         r_sym_cnt  <= '0;
         r_gap_cnt  <= '0;
         r_emitter  <= 1'b0;
         r_cur_bit  <= 1'b0;
         r_done     <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_half_cnt <= w_half_cnt_nxt;
         r_sym_cnt  <= w_sym_cnt_nxt;
         r_gap_cnt  <= w_gap_cnt_nxt;
         r_emitter  <= w_emitter_nxt;
         r_cur_bit  <= w_cur_bit_nxt;
         r_done     <= w_done_nxt;
         r_ready    <= w_ready_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   assign ready       = r_ready;
   assign busy        = r_busy;
   assign emitter     = r_emitter;
   assign current_bit = r_cur_bit;
   assign done        = r_done;

endmodule

// File: tb/tb_frequency_pixel_emitter.sv
// Directed testbench for frequency_pixel_emitter.
// Bench configuration: HALF0 = 5, HALF1 = 2, 20-cycle symbols, a 10-cycle gap
// and 4-bit words. Cycle c of a word is the c-th clock period after the
// acceptance edge (c = 0 is the first cycle with busy high).
module tb_frequency_pixel_emitter;

   localparam int SYM = 20;
   localparam int GAP = 10;
   localparam int WW  = 4;
   localparam int TOT = WW * SYM + GAP;   // 90 busy cycles; done appears in cycle 90

   logic          clock;
   logic          reset;
   logic [WW-1:0] data;
   logic          start;
   logic          stop;
   logic          ready;
   logic          busy;
   logic          emitter;
   logic          current_bit;
   logic          done;

   int n_checks;
   int n_errors;

   frequency_pixel_emitter #(
      .CLOCK_FREQUENCY (1000),
      .FREQUENCY0      (100),
      .FREQUENCY1      (250),
      .WORD_WIDTH      (WW),
      .SYMBOL_CYCLES   (SYM),
      .GAP_CYCLES      (GAP)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .data        (data),
      .start       (start),
      .stop        (stop),
      .ready       (ready),
      .busy        (busy),
      .emitter     (emitter),
      .current_bit (current_bit),
      .done        (done)
   );

   // 10-time-unit clock; rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a word on the next rising edge. With keep set, start stays high afterwards.
   task automatic accept(input logic [WW-1:0] w, input logic keep);
      @(negedge clock);
      data  = w;
      start = 1'b1;
      @(posedge clock);
      #1;
      if (!keep) start = 1'b0;
   endtask

   // Observe ncyc cycles of a word that has just been accepted and compare
   // every output against the burst model. With keep set, the next word is
   // presented during the done cycle. Otherwise the data input is scrambled
   // and start is pulsed mid-word, and the word on air must not change.
   task automatic run_word(input logic [WW-1:0] w, input logic keep,
                           input logic [WW-1:0] nxt, input int ncyc, input int exp_rises);
      int   rises;
      int   gap_low;
      logic prev;
      logic e_em;
      logic e_bit;
      rises   = 0;
      gap_low = 0;
      prev    = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clock);
         if (c < WW * SYM) begin
            e_bit = w[WW-1-(c/SYM)];
            e_em  = (((c % SYM) / (e_bit ? 2 : 5)) % 2) == 0;
            check($sformatf("em_c%0d", c), {31'd0, emitter}, {31'd0, e_em});
            check($sformatf("bit_c%0d", c), {31'd0, current_bit}, {31'd0, e_bit});
            check($sformatf("busy_c%0d", c), {31'd0, busy}, 32'd1);
            check($sformatf("done_c%0d", c), {31'd0, done}, 32'd0);
         end else if (c < TOT) begin
            check($sformatf("gap_em_c%0d", c), {31'd0, emitter}, 32'd0);
            check($sformatf("gap_busy_c%0d", c), {31'd0, busy}, 32'd1);
            check($sformatf("gap_done_c%0d", c), {31'd0, done}, 32'd0);
         end else begin
            check("done_pulse", {31'd0, done}, 32'd1);
            check("done_ready", {31'd0, ready}, 32'd1);
            check("done_busy", {31'd0, busy}, 32'd0);
            check("done_em", {31'd0, emitter}, 32'd0);
         end
         if (emitter && !prev) rises++;
         if (c >= WW * SYM && !emitter) gap_low++;
         prev = emitter;
         if (!keep && c == 30) begin
            data  = ~w;
            start = 1'b1;
         end
         if (!keep && c == 31) start = 1'b0;
         if (keep && c == TOT) data = nxt;
      end
      if (ncyc == TOT + 1) begin
         check("rises", rises, exp_rises);
         check("low_before_next", gap_low, GAP + 1);
      end
   endtask

   initial begin
      int done_seen;
      n_checks = 0;
      n_errors = 0;
      reset = 1'b0;
      data  = '0;
      start = 1'b0;
      stop  = 1'b0;

      // 1. Reset asserted between edges takes effect at once.
      #2 reset = 1'b1;
      #1;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_em", {31'd0, emitter}, 32'd0);
      check("rst_bit", {31'd0, current_bit}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_em", {31'd0, emitter}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // 2. Word 1010: 5 + 2 + 5 + 2 rising edges.
      accept(4'b1010, 1'b0);
      run_word(4'b1010, 1'b0, 4'b0000, TOT + 1, 14);

      // 3. Back-to-back: 1111 (20 rises), then 0000 taken on the done cycle (8 rises).
      repeat (2) @(negedge clock);
      accept(4'b1111, 1'b1);
      run_word(4'b1111, 1'b1, 4'b0000, TOT + 1, 20);
      @(posedge clock);
      #1 start = 1'b0;
      run_word(4'b0000, 1'b0, 4'b0000, TOT + 1, 8);

      // 4. Abort word 0110 during cycle 37, while the bit-1 burst is high.
      repeat (2) @(negedge clock);
      accept(4'b0110, 1'b0);
      run_word(4'b0110, 1'b0, 4'b0000, 38, 0);
      stop = 1'b1;
      @(posedge clock);
      #1 stop = 1'b0;
      @(negedge clock);
      check("abort_em", {31'd0, emitter}, 32'd0);
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_bit", {31'd0, current_bit}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < TOT; i++) begin
         @(negedge clock);
         if (done) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      accept(4'b0110, 1'b0);
      run_word(4'b0110, 1'b0, 4'b0000, TOT + 1, 14);

      // 5. start and stop together in IDLE: the word is not accepted.
      @(negedge clock);
      data  = 4'b1111;
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clock);
      check("ss_ready", {31'd0, ready}, 32'd1);
      check("ss_busy", {31'd0, busy}, 32'd0);
      check("ss_em", {31'd0, emitter}, 32'd0);

      // 6. Asynchronous reset in the gap of word 1010.
      accept(4'b1010, 1'b0);
      run_word(4'b1010, 1'b0, 4'b0000, 86, 0);
      #2 reset = 1'b1;
      #1;
      check("gaprst_ready", {31'd0, ready}, 32'd1);
      check("gaprst_busy", {31'd0, busy}, 32'd0);
      check("gaprst_em", {31'd0, emitter}, 32'd0);
      check("gaprst_done", {31'd0, done}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (done) done_seen++;
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (done) done_seen++;
      end
      check("gaprst_no_done", done_seen, 0);
      check("gaprst_idle_ready", {31'd0, ready}, 32'd1);
      accept(4'b1111, 1'b0);
      run_word(4'b1111, 1'b0, 4'b0000, TOT + 1, 20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
